mem_access_unit: RTL and testbench

Load/store unit sitting directly downstream of the multicycle RV32I datapath, between its address/store-data registers and the single-ported memory. It accepts one access request at a time and drives a word-aligned memory request with the correct byte enables and lane-replicated store data. It waits for the memory handshake and returns load data already lane-selected and sign- or zero-extended, ready for the register-file write mux. Misaligned accesses, illegal funct3 encodings and memory timeouts are reported as errors instead of being issued.

---
 rtl/mem_access_unit.sv | 189 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store unit between the RV32I datapath and a single-ported memory.
// Issues word-aligned requests with byte enables and returns extended load data.
module mem_access_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [1:0]  rsp_err_code,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byte_enable,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp
);

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_FUNCT3   = 2'b11;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    typedef struct packed {
        logic       write;
        logic [2:0] funct3;
        logic [1:0] offset;
    } ctx_t;

    state_t      state, state_nxt;
    ctx_t        ctx_q, ctx_in;
    logic [31:0] cnt;
    logic        accept, legal, tmo_hit;
    logic [1:0]  chk_code;
    logic [3:0]  be_in;
    logic [31:0] wdata_in;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;

    assign accept = req_valid && (state == IDLE);

    // Request decode: legality, alignment, lane mask and replicated store data.
    always_comb begin
        ctx_in = '{write: req_write, funct3: req_funct3, offset: req_addr[1:0]};
        legal  = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = !req_write;
            default:                legal = 1'b0;
        endcase

        chk_code = ERR_NONE;
        if (!legal)
            chk_code = ERR_FUNCT3;
        else if (req_funct3[1:0] == 2'b01 && req_addr[0])
            chk_code = ERR_MISALIGN;
        else if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00)
            chk_code = ERR_MISALIGN;

        case (req_funct3[1:0])
            2'b00: begin
                be_in    = 4'b0001 << req_addr[1:0];
                wdata_in = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                be_in    = 4'b0011 << req_addr[1:0];
                wdata_in = {2{req_wdata[15:0]}};
            end
            default: begin
                be_in    = 4'b1111;
                wdata_in = req_wdata;
            end
        endcase
    end

    always_comb begin
        byte_sel = mem_rdata[{ctx_q.offset, 3'b000} +: 8];
        half_sel = ctx_q.offset[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (ctx_q.funct3)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_data = {24'b0, byte_sel};
            3'b101:  load_data = {16'b0, half_sel};
            default: load_data = mem_rdata;
        endcase
    end

    // Counter value TIMEOUT-1 marks the last allowed strobe cycle; mem_resp
    // in that same cycle still takes priority.
    always_comb begin
        tmo_hit = 1'b0;
        if (TIMEOUT != 0)
            tmo_hit = (state == ACCESS) && !mem_resp && (cnt == 32'(TIMEOUT - 1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (accept)
                    state_nxt = (chk_code != ERR_NONE) ? RESP : ACCESS;
            end
            ACCESS: begin
                if (mem_resp || tmo_hit)
                    state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign rsp_err = rsp_valid && (rsp_err_code != ERR_NONE);

    // Memory outputs are zero outside ACCESS so error paths never touch memory.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctx_q           <= '0;
            cnt             <= '0;
            rsp_rdata       <= '0;
            rsp_err_code    <= ERR_NONE;
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            mem_address     <= '0;
            mem_wdata       <= '0;
            mem_byte_enable <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        ctx_q        <= ctx_in;
                        cnt          <= '0;
                        rsp_err_code <= chk_code;
                        if (chk_code == ERR_NONE) begin
                            mem_read        <= !req_write;
                            mem_write       <= req_write;
                            mem_address     <= {req_addr[31:2], 2'b00};
                            mem_wdata       <= wdata_in;
                            mem_byte_enable <= be_in;
                        end else begin
                            rsp_rdata <= '0;
                        end
                    end
                end
                ACCESS: begin
                    cnt <= cnt + 32'd1;
                    if (mem_resp || tmo_hit) begin
                        mem_read        <= 1'b0;
                        mem_write       <= 1'b0;
                        mem_address     <= '0;
                        mem_wdata       <= '0;
                        mem_byte_enable <= '0;
                        if (mem_resp) begin
                            rsp_rdata <= ctx_q.write ? 32'd0 : load_data;
                        end else begin
                            rsp_rdata    <= '0;
                            rsp_err_code <= ERR_TIMEOUT;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with TIMEOUT=4.
module tb_mem_access_unit;
    localparam int TMO = 4;

    logic        clk, rst;
    logic        req_valid, req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err_code;
    logic        mem_read, mem_write;
    logic [31:0] mem_address, mem_wdata, mem_rdata;
    logic [3:0]  mem_byte_enable;
    logic        mem_resp;

    int checks = 0;
    int errors = 0;

    mem_access_unit #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_err_code(rsp_err_code), .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_byte_enable(mem_byte_enable), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one request from IDLE; pulses mem_resp in the k-th strobe cycle (k=0: never).
    // lat counts cycles from accept edge to the rsp_valid cycle (0 = never seen).
    task automatic access(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata, input int k,
                          output int strobes, output logic saw_rd, output logic saw_wr,
                          output logic [31:0] o_addr, output logic [31:0] o_wdata,
                          output logic [3:0] o_be, output int lat, output logic o_err,
                          output logic [1:0] o_code, output logic [31:0] o_rdata,
                          output logic o_rdy);
        strobes = 0; saw_rd = 1'b0; saw_wr = 1'b0; lat = 0;
        o_addr = '0; o_wdata = '0; o_be = '0; o_err = 1'b0; o_code = '0; o_rdata = '0;
        req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        mem_rdata = rdata;
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            mem_resp = 1'b0;
            if (rsp_valid) begin
                lat = c; o_err = rsp_err; o_code = rsp_err_code; o_rdata = rsp_rdata;
                break;
            end
            if (mem_read || mem_write) begin
                strobes++;
                if (strobes == 1) begin
                    o_addr = mem_address; o_wdata = mem_wdata; o_be = mem_byte_enable;
                end
                saw_rd = saw_rd | mem_read;
                saw_wr = saw_wr | mem_write;
                if (strobes == k) mem_resp = 1'b1;
            end
            @(negedge clk);
        end
        mem_resp = 1'b0;
        @(negedge clk);
        o_rdy = req_ready;
    endtask

    task automatic test_reset();
        rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0; mem_rdata = '0; mem_resp = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", req_ready); end
        checks++; if ({rsp_valid, rsp_err, rsp_err_code, mem_read, mem_write} !== 6'b0) begin
            errors++; $display("FAIL reset_flags got %b want 000000", {rsp_valid, rsp_err, rsp_err_code, mem_read, mem_write}); end
        checks++; if ({rsp_rdata, mem_address, mem_wdata, mem_byte_enable} !== 100'b0) begin
            errors++; $display("FAIL reset_data got %h %h %h %h want 0", rsp_rdata, mem_address, mem_wdata, mem_byte_enable); end
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_lw();
        int s, lat; logic rd, wr, err, rdy; logic [31:0] a, wd, rdat; logic [3:0] be; logic [1:0] code;
        access(1'b0, 3'b010, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 3, s, rd, wr, a, wd, be, lat, err, code, rdat, rdy);
        checks++; if (a !== 32'h0000_1004) begin errors++; $display("FAIL lw_addr got %h want 00001004", a); end
        checks++; if (be !== 4'b1111) begin errors++; $display("FAIL lw_be got %b want 1111", be); end
        checks++; if ({rd, wr} !== 2'b10 || s !== 3) begin errors++; $display("FAIL lw_strobe got rd=%b wr=%b n=%0d want rd=1 wr=0 n=3", rd, wr, s); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL lw_latency got %0d want 4", lat); end
        checks++; if (rdat !== 32'hDEAD_BEEF || err !== 1'b0) begin errors++; $display("FAIL lw_rsp got %h err=%b want deadbeef err=0", rdat, err); end
        checks++; if (rdy !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL lw_ready got rdy=%b rv=%b want 1 0", rdy, rsp_valid); end
        checks++; if (rsp_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_hold got %h want deadbeef", rsp_rdata); end
    endtask

    task automatic test_sub_loads();
        logic [2:0]  f3  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] ad  [4] = '{32'h1003, 32'h1003, 32'h1002, 32'h1002};
        logic [31:0] exp [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80F0, 32'h0000_80F0};
        logic [3:0]  ebe [4] = '{4'b1000, 4'b1000, 4'b1100, 4'b1100};
        int s, lat; logic rd, wr, err, rdy; logic [31:0] a, wd, rdat; logic [3:0] be; logic [1:0] code;
        for (int i = 0; i < 4; i++) begin
            access(1'b0, f3[i], ad[i], 32'h0, 32'h80F0_7F01, 2, s, rd, wr, a, wd, be, lat, err, code, rdat, rdy);
            checks++; if (rdat !== exp[i] || err !== 1'b0) begin errors++; $display("FAIL subload%0d_data got %h err=%b want %h err=0", i, rdat, err, exp[i]); end
            checks++; if (be !== ebe[i] || a !== 32'h1000) begin errors++; $display("FAIL subload%0d_be got %b %h want %b 00001000", i, be, a, ebe[i]); end
        end
    endtask

    task automatic test_stores();
        int s, lat; logic rd, wr, err, rdy; logic [31:0] a, wd, rdat; logic [3:0] be; logic [1:0] code;
        access(1'b1, 3'b000, 32'h2001, 32'h1234_56AB, 32'hFFFF_FFFF, 1, s, rd, wr, a, wd, be, lat, err, code, rdat, rdy);
        checks++; if (wd !== 32'hABAB_ABAB || be !== 4'b0010 || a !== 32'h2000) begin
            errors++; $display("FAIL sb_mem got %h %b %h want ababab ab 0010 00002000", wd, be, a); end
        checks++; if ({rd, wr} !== 2'b01 || lat !== 2) begin errors++; $display("FAIL sb_strobe got rd=%b wr=%b lat=%0d want 0 1 2", rd, wr, lat); end
        checks++; if (rdat !== 32'h0 || err !== 1'b0) begin errors++; $display("FAIL sb_rsp got %h err=%b want 0 0", rdat, err); end
        access(1'b1, 3'b001, 32'h2002, 32'h1234_56AB, 32'h0, 2, s, rd, wr, a, wd, be, lat, err, code, rdat, rdy);
        checks++; if (wd !== 32'h56AB_56AB || be !== 4'b1100) begin errors++; $display("FAIL sh_mem got %h %b want 56ab56ab 1100", wd, be); end
        access(1'b1, 3'b010, 32'h2008, 32'hCAFE_0001, 32'h0, 1, s, rd, wr, a, wd, be, lat, err, code, rdat, rdy);
        checks++; if (wd !== 32'hCAFE_0001 || be !== 4'b1111 || a !== 32'h2008) begin errors++; $display("FAIL sw_mem got %h %b %h want cafe0001 1111 00002008", wd, be, a); end
    endtask

    task automatic test_errors();
        logic        w   [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [2:0]  f3  [5] = '{3'b010, 3'b001, 3'b011, 3'b110, 3'b100};
        logic [31:0] ad  [5] = '{32'h3002, 32'h3001, 32'h3000, 32'h3000, 32'h3000};
        logic [1:0]  ec  [5] = '{2'b01, 2'b01, 2'b11, 2'b11, 2'b11};
        int s, lat; logic rd, wr, err, rdy; logic [31:0] a, wd, rdat; logic [3:0] be; logic [1:0] code;
        for (int i = 0; i < 5; i++) begin
            access(w[i], f3[i], ad[i], 32'hFFFF_FFFF, 32'h1111_2222, 1, s, rd, wr, a, wd, be, lat, err, code, rdat, rdy);
            checks++; if (s !== 0 || lat !== 1) begin errors++; $display("FAIL err%0d_nomem got strobes=%0d lat=%0d want 0 1", i, s, lat); end
            checks++; if (err !== 1'b1 || code !== ec[i] || rdat !== 32'h0) begin
                errors++; $display("FAIL err%0d_rsp got err=%b code=%b data=%h want 1 %b 0", i, err, code, rdat, ec[i]); end
        end
    endtask

    task automatic test_timeout();
        int s, lat; logic rd, wr, err, rdy; logic [31:0] a, wd, rdat; logic [3:0] be; logic [1:0] code;
        access(1'b0, 3'b010, 32'h4000, 32'h0, 32'h5555_AAAA, 0, s, rd, wr, a, wd, be, lat, err, code, rdat, rdy);
        checks++; if (s !== TMO || lat !== TMO + 1) begin errors++; $display("FAIL tmo_len got strobes=%0d lat=%0d want 4 5", s, lat); end
        checks++; if (err !== 1'b1 || code !== 2'b10) begin errors++; $display("FAIL tmo_rsp got err=%b code=%b want 1 10", err, code); end
        access(1'b0, 3'b010, 32'h4000, 32'h0, 32'h5555_AAAA, TMO, s, rd, wr, a, wd, be, lat, err, code, rdat, rdy);
        checks++; if (err !== 1'b0 || code !== 2'b00 || rdat !== 32'h5555_AAAA) begin
            errors++; $display("FAIL tmo_edge got err=%b code=%b data=%h want 0 00 5555aaaa", err, code, rdat); end
        checks++; if (lat !== TMO + 1) begin errors++; $display("FAIL tmo_edge_lat got %0d want 5", lat); end
    endtask

    task automatic test_back_to_back();
        int s, lat; logic rd, wr, err, rdy; logic [31:0] a, wd, rdat; logic [3:0] be; logic [1:0] code;
        access(1'b0, 3'b101, 32'h5002, 32'h0, 32'hBEEF_0000, 1, s, rd, wr, a, wd, be, lat, err, code, rdat, rdy);
        checks++; if (lat !== 2 || rdat !== 32'h0000_BEEF) begin errors++; $display("FAIL zw_lhu got lat=%0d data=%h want 2 0000beef", lat, rdat); end
        access(1'b0, 3'b000, 32'h5001, 32'h0, 32'h0000_7F00, 1, s, rd, wr, a, wd, be, lat, err, code, rdat, rdy);
        checks++; if (lat !== 2 || rdat !== 32'h0000_007F) begin errors++; $display("FAIL zw_lb got lat=%0d data=%h want 2 0000007f", lat, rdat); end
    endtask

    task automatic test_reset_mid();
        int s, lat; logic rd, wr, err, rdy; logic [31:0] a, wd, rdat; logic [3:0] be; logic [1:0] code;
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h1004;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL rmid_active got %b want 1", mem_read); end
        #2 rst = 1'b0;
        #1;
        checks++; if ({mem_read, mem_write, mem_byte_enable, rsp_valid} !== 7'b0 || mem_address !== 32'h0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL rmid_clear got rd=%b be=%b addr=%h rdy=%b want 0 0 0 1", mem_read, mem_byte_enable, mem_address, req_ready); end
        @(negedge clk);
        rst = 1'b1; mem_resp = 1'b1;
        @(negedge clk);
        mem_resp = 1'b0;
        checks++; if (rsp_valid !== 1'b0 || mem_read !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL rmid_stray got rv=%b rd=%b rdy=%b want 0 0 1", rsp_valid, mem_read, req_ready); end
        access(1'b0, 3'b010, 32'h1008, 32'h0, 32'hCAFE_F00D, 2, s, rd, wr, a, wd, be, lat, err, code, rdat, rdy);
        checks++; if (rdat !== 32'hCAFE_F00D || err !== 1'b0 || lat !== 3) begin
            errors++; $display("FAIL rmid_next got %h err=%b lat=%0d want cafef00d 0 3", rdat, err, lat); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sub_loads();
        test_stores();
        test_errors();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
